nano_mem_responder: RTL

//  Memory-side responder for the NanoCPU bus: 256 x 16-bit storage answering the CPU's

---
 rtl/nano_mem_pkg.sv | 17 +
 rtl/nano_mem_loader.sv | 94 +++++++++
 rtl/nano_mem_responder.sv | 90 +++++++++
 3 files changed

// File: rtl/nano_mem_pkg.sv
// Shared types and defaults for the NanoCPU memory responder and its byte-stream loader.
package nano_mem_pkg;

    localparam int unsigned ADDR_W_DEF   = 8;
    localparam int unsigned DATA_W_DEF   = 16;
    localparam logic [7:0]  WP_LIMIT_DEF = 8'h20;

    typedef enum logic [1:0] {
        IDLE,
        HI,
        LO,
        DONE
    } load_state_t;

    typedef logic [15:0] word_t;

endpackage

// File: rtl/nano_mem_loader.sv
// Byte-stream program loader: assembles high/low byte pairs into words and issues one
// memory write strobe per completed word while holding the CPU off the bus.
module nano_mem_loader
    import nano_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              ck,
    input  logic              rst,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [ADDR_W:0]   load_len,
    input  logic              load_valid,
    input  logic [7:0]        load_data,
    output logic              load_ready,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output word_t             wr_data
);

    load_state_t       state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [7:0]        hi_q, hi_d;
    logic              hold_q;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        load_ready = 1'b0;
        load_done  = 1'b0;
        wr_en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_start) begin
                    if (load_len != '0) begin
                        state_d = HI;
                        ptr_d   = load_base;
                        cnt_d   = load_len;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            HI: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    hi_d    = load_data;
                    state_d = LO;
                end
            end
            LO: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    wr_en   = 1'b1;
                    ptr_d   = ptr_q + ADDR_W'(1);
                    cnt_d   = cnt_q - (ADDR_W + 1)'(1);
                    state_d = (cnt_q == (ADDR_W + 1)'(1)) ? DONE : HI;
                end
            end
            DONE: begin
                load_done = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign wr_addr  = ptr_q;
    assign wr_data  = {hi_q, load_data};
    assign cpu_hold = hold_q;

    // Hold comes straight from a flop so the CPU side never sees decode glitches.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            hold_q  <= (state_d == HI) || (state_d == LO);
        end
    end

endmodule

// File: rtl/nano_mem_responder.sv
// NanoCPU memory responder: 2**ADDR_W words, zero-wait reads, single-cycle writes, run-time loader.
// Optional CPU write protection below WP_LIMIT is enabled by defining NANO_MEM_WP_EN.
module nano_mem_responder
    import nano_mem_pkg::*;
#(
    parameter int unsigned       ADDR_W   = ADDR_W_DEF,
    parameter int unsigned       DATA_W   = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] WP_LIMIT = ADDR_W'(WP_LIMIT_DEF)
) (
    input  logic              ck,
    input  logic              rst,
    input  logic              ce,
    input  logic              we,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] dataW,
    output logic [DATA_W-1:0] dataR,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [ADDR_W:0]   load_len,
    input  logic              load_valid,
    input  logic [7:0]        load_data,
    output logic              load_ready,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              wp_err
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    word_t             ld_data;
    logic              cpu_we;
    logic              wp_block;

    nano_mem_loader #(
        .ADDR_W (ADDR_W)
    ) u_loader (
        .ck         (ck),
        .rst        (rst),
        .load_start (load_start),
        .load_base  (load_base),
        .load_len   (load_len),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .wr_en      (ld_we),
        .wr_addr    (ld_addr),
        .wr_data    (ld_data)
    );

    // Loader writes only happen while cpu_hold is high, so this also drops colliding CPU writes.
    assign cpu_we = ce && we && !cpu_hold;

`ifdef NANO_MEM_WP_EN
    logic wp_err_q;

    assign wp_block = (address < WP_LIMIT);
    assign wp_err   = wp_err_q;

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            wp_err_q <= 1'b0;
        end else if (cpu_we && wp_block) begin
            wp_err_q <= 1'b1;
        end
    end
`else
    logic unused_wp_limit;

    assign unused_wp_limit = ^WP_LIMIT;
    assign wp_block        = 1'b0;
    assign wp_err          = 1'b0;
`endif

    // Storage is deliberately not reset so a loaded image survives a CPU reset.
    always_ff @(posedge ck) begin
        if (ld_we) begin
            mem[ld_addr] <= ld_data;
        end else if (cpu_we && !wp_block) begin
            mem[address] <= dataW;
        end
    end

    assign dataR = mem[address];

endmodule
